// File: rtl/display_pkg.sv
// Shared constants and glyph table for the HEX/LED display controller.
// LED mode encodings, dark segment code and the 0-F seven-segment decoder.
package display_pkg;

    localparam logic [1:0] LED_DIRECT = 2'b00;
    localparam logic [1:0] LED_BLINK  = 2'b01;
    localparam logic [1:0] LED_CHASE  = 2'b10;
    localparam logic [1:0] LED_OFF    = 2'b11;

    localparam logic [6:0] SEG_DARK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; every code is a visible glyph.
    function automatic logic [6:0] seg_glyph(input logic [3:0] v);
        logic [6:0] s;
        s = SEG_DARK;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
            default: s = SEG_DARK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Combinational hex digit to seven-segment decoder.
// One instance per display digit.
module seg7_glyph
    import display_pkg::*;
(
    input  logic [3:0] val_i,
    output logic [6:0] seg_o
);

    assign seg_o = seg_glyph(val_i);

endmodule

// File: rtl/hex_display_ctrl.sv
// Registered display controller for N seven-segment digits and M LEDs.
// Shadowed inputs, blink/chase timers and registered segment/LED outputs.
module hex_display_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int NUM_LEDS   = 10,
    parameter int BLINK_DIV  = 25_000_000,
    parameter int CHASE_DIV  = 5_000_000
) (
    input  logic                    CLOCK_50,
    input  logic                    resetn,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digit_data,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [NUM_LEDS-1:0]     led_data,
    input  logic [1:0]              led_mode,
    input  logic                    freeze,
    output logic [7*NUM_DIGITS-1:0] hex_out,
    output logic [NUM_LEDS-1:0]     ledr,
    output logic                    blink_phase
);

    localparam int BW = $clog2(BLINK_DIV);
    localparam int CW = $clog2(CHASE_DIV);
    localparam int PW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
        $error("NUM_DIGITS must be 1..8");
    end
    if (NUM_LEDS < 1 || NUM_LEDS > 16) begin : g_bad_leds
        $error("NUM_LEDS must be 1..16");
    end
    if (BLINK_DIV < 2 || CHASE_DIV < 2) begin : g_bad_div
        $error("BLINK_DIV and CHASE_DIV must be >= 2");
    end

    logic [4*NUM_DIGITS-1:0] dig_q;
    logic [NUM_DIGITS-1:0]   blank_q;
    logic [NUM_DIGITS-1:0]   bmask_q;
    logic [NUM_LEDS-1:0]     led_q;
    logic [1:0]              mode_q;

    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;
    logic [CW-1:0] ccnt_q, ccnt_d;
    logic [PW-1:0] ptr_q, ptr_d;

    logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
    logic [NUM_LEDS-1:0]     ledr_q, ledr_d;

    logic [6:0] glyph [NUM_DIGITS];
    logic       chase_enter;

    assign chase_enter = load && (led_mode == LED_CHASE)
                         && (mode_q != LED_CHASE);

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        seg7_glyph u_glyph (
            .val_i (dig_q[4*i +: 4]),
            .seg_o (glyph[i])
        );
    end

    // Capture all display inputs when load is asserted.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            dig_q   <= '0;
            blank_q <= '1;
            bmask_q <= '0;
            led_q   <= '0;
            mode_q  <= LED_OFF;
        end else if (load) begin
            dig_q   <= digit_data;
            blank_q <= blank_mask;
            bmask_q <= blink_mask;
            led_q   <= led_data;
            mode_q  <= led_mode;
        end
    end

    // Next state of blink and chase timers; entering chase restarts it.
    always_comb begin
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        ccnt_d  = ccnt_q;
        ptr_d   = ptr_q;
        if (!freeze) begin
            if (bcnt_q == BW'(BLINK_DIV - 1)) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
            if (ccnt_q == CW'(CHASE_DIV - 1)) begin
                ccnt_d = '0;
                if (ptr_q == PW'(NUM_LEDS - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end else begin
                ccnt_d = ccnt_q + 1'b1;
            end
        end
        if (chase_enter) begin
            ccnt_d = '0;
            ptr_d  = '0;
        end
    end

    // Timer registers.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            bcnt_q  <= '0;
            phase_q <= 1'b1;
            ccnt_q  <= '0;
            ptr_q   <= '0;
        end else begin
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            ccnt_q  <= ccnt_d;
            ptr_q   <= ptr_d;
        end
    end

    // Segment masking and LED mode selection ahead of the output flops.
    always_comb begin
        hex_d  = '1;
        ledr_d = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (blank_q[i] || (bmask_q[i] && !phase_q)) begin
                hex_d[7*i +: 7] = SEG_DARK;
            end else begin
                hex_d[7*i +: 7] = glyph[i];
            end
        end
        case (mode_q)
            LED_DIRECT: ledr_d = led_q;
            LED_BLINK:  ledr_d = phase_q ? led_q : '0;
            LED_CHASE:  ledr_d = NUM_LEDS'(1) << ptr_q;
            default:    ledr_d = '0;
        endcase
    end

    // Output registers.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            hex_q  <= '1;
            ledr_q <= '0;
        end else begin
            hex_q  <= hex_d;
            ledr_q <= ledr_d;
        end
    end

    assign hex_out     = hex_q;
    assign ledr        = ledr_q;
    assign blink_phase = phase_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed plus random bench for hex_display_ctrl.
// Reference model tracks elapsed timer cycles and derives phase/pointer arithmetically.
module tb_hex_display_ctrl;

    localparam int ND = 6;
    localparam int NL = 10;
    localparam int BD = 4;
    localparam int CD = 3;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            load = 1'b0;
    logic [4*ND-1:0] digit_data = '0;
    logic [ND-1:0]   blank_mask = '0;
    logic [ND-1:0]   blink_mask = '0;
    logic [NL-1:0]   led_data = '0;
    logic [1:0]      led_mode = 2'b00;
    logic            freeze = 1'b0;
    logic [7*ND-1:0] hex_out;
    logic [NL-1:0]   ledr;
    logic            blink_phase;

    int total = 0;
    int bad   = 0;

    hex_display_ctrl #(
        .NUM_DIGITS (ND),
        .NUM_LEDS   (NL),
        .BLINK_DIV  (BD),
        .CHASE_DIV  (CD)
    ) dut (
        .CLOCK_50    (clk),
        .resetn      (resetn),
        .load        (load),
        .digit_data  (digit_data),
        .blank_mask  (blank_mask),
        .blink_mask  (blink_mask),
        .led_data    (led_data),
        .led_mode    (led_mode),
        .freeze      (freeze),
        .hex_out     (hex_out),
        .ledr        (ledr),
        .blink_phase (blink_phase)
    );

    always #5 clk = ~clk;

    // Lit segments per hex value, written as segment letters.
    string lit [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                        "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                        "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    // Model state
    logic [4*ND-1:0] m_dig;
    logic [ND-1:0]   m_blank, m_bm;
    logic [NL-1:0]   m_led;
    logic [1:0]      m_mode;
    int              bel, cel;
    logic [7*ND-1:0] exp_hex;
    logic [NL-1:0]   exp_led;
    logic            exp_ph;

    function automatic logic [6:0] glyph_of(input logic [3:0] v);
        logic [6:0] r;
        string s;
        int idx;
        r = 7'h7F;
        s = lit[v];
        for (int k = 0; k < s.len(); k++) begin
            idx = int'(s[k]) - 97;
            r[idx] = 1'b0;
        end
        return r;
    endfunction

    function automatic logic phase_of(input int n);
        return ((n / BD) % 2) == 0;
    endfunction

    task automatic model_edge();
        logic ph;
        int ptr;
        if (!resetn) begin
            m_dig = '0; m_blank = '1; m_bm = '0; m_led = '0;
            m_mode = 2'b11; bel = 0; cel = 0;
            exp_hex = '1; exp_led = '0;
        end else begin
            ph = phase_of(bel);
            ptr = (cel / CD) % NL;
            for (int i = 0; i < ND; i++) begin
                if (m_blank[i] || (m_bm[i] && !ph))
                    exp_hex[7*i +: 7] = 7'h7F;
                else
                    exp_hex[7*i +: 7] = glyph_of(m_dig[4*i +: 4]);
            end
            case (m_mode)
                2'b00: exp_led = m_led;
                2'b01: exp_led = ph ? m_led : '0;
                2'b10: exp_led = NL'(1 << ptr);
                default: exp_led = '0;
            endcase
            if (load && led_mode == 2'b10 && m_mode != 2'b10) cel = 0;
            else if (!freeze) cel++;
            if (!freeze) bel++;
            if (load) begin
                m_dig = digit_data; m_blank = blank_mask; m_bm = blink_mask;
                m_led = led_data; m_mode = led_mode;
            end
        end
        exp_ph = phase_of(bel);
    endtask

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock: model, edge, sample on the falling edge.
    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        chk("hex", 64'(hex_out), 64'(exp_hex));
        chk("ledr", 64'(ledr), 64'(exp_led));
        chk("phase", 64'(blink_phase), 64'(exp_ph));
    endtask

    logic       p0;
    logic [9:0] l0;

    initial begin
        @(negedge clk);
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk("idle_hex", 64'(hex_out), 64'h3FF_FFFF_FFFF);

        // Load FEDCBA, direct LEDs
        load = 1'b1; digit_data = 24'hFEDCBA; blank_mask = '0;
        blink_mask = '0; led_mode = 2'b00; led_data = 10'h2A5;
        step();
        load = 1'b0;
        chk("hex_lag", 64'(hex_out), 64'h3FF_FFFF_FFFF);
        step();
        chk("hex0_A", 64'(hex_out[6:0]), 64'(7'b0001000));
        chk("hex5_F", 64'(hex_out[41:35]), 64'(7'b0001110));
        chk("ledr_direct", 64'(ledr), 64'h2A5);

        // Blink digit0, blank digit1
        load = 1'b1; blink_mask = 6'b000001; blank_mask = 6'b000010;
        step();
        load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            chk("dig1_dark", 64'(hex_out[13:7]), 64'h7F);
        end

        // Chase from direct
        load = 1'b1; led_mode = 2'b10;
        step();
        load = 1'b0;
        step();
        chk("chase_first", 64'(ledr), 64'h001);
        for (int i = 0; i < 32; i++) step();
        load = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 8; i++) step();

        // Freeze mid-chase
        freeze = 1'b1;
        step();
        p0 = blink_phase; l0 = ledr;
        for (int i = 0; i < 9; i++) begin
            step();
            chk("frz_ledr", 64'(ledr), 64'(l0));
            chk("frz_phase", 64'(blink_phase), 64'(p0));
        end
        freeze = 1'b0;
        for (int i = 0; i < 12; i++) step();

        // Load and reset together
        load = 1'b1; resetn = 1'b0; blank_mask = '0; led_mode = 2'b00;
        led_data = 10'h3FF;
        step();
        chk("rst_hex", 64'(hex_out), 64'h3FF_FFFF_FFFF);
        chk("rst_ledr", 64'(ledr), 64'h0);
        load = 1'b0; resetn = 1'b1;
        step();
        chk("rst_hold", 64'(hex_out), 64'h3FF_FFFF_FFFF);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            resetn = ($urandom_range(0, 79) != 0);
            load = ($urandom_range(0, 3) == 0);
            freeze = ($urandom_range(0, 5) == 0);
            if (load) begin
                digit_data = 24'($urandom);
                blank_mask = 6'($urandom) & 6'($urandom);
                blink_mask = 6'($urandom);
                led_data = 10'($urandom);
                led_mode = 2'($urandom);
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hex_display_ctrl.md
# hex_display_ctrl

Parametrised, registered display controller for the game's seven-segment digits and LED bar. It generalises the current fixed six-digit pass-through to N digits and M LEDs. It adds per-digit blanking and blinking, a full 0–F glyph set (blank is a separate control, not a digit code), and LED modes (direct, blink, chase, off) driven by internal timers. It sits between the game FSM/score logic and the board's HEX/LEDR pins.

## Interface
Parameters:
- NUM_DIGITS, 6, number of seven-segment digits (1–8)
- NUM_LEDS, 10, LED bar width (1–16)
- BLINK_DIV, 25_000_000, clock cycles per blink half-period (≥2)
- CHASE_DIV, 5_000_000, clock cycles per chase step (≥2)

Ports:
- CLOCK_50  in  1  system clock
- resetn  in  1  reset; one clock; reset is synchronous and active-low
- load  in  1  capture all data/control inputs into shadow registers
- digit_data  in  4*NUM_DIGITS  hex value per digit, digit i at [4i+3:4i]
- blank_mask  in  NUM_DIGITS  1 = digit dark, overrides everything
- blink_mask  in  NUM_DIGITS  1 = digit dark during hidden blink phase
- led_data  in  NUM_LEDS  LED pattern for direct/blink modes
- led_mode  in  2  00 direct, 01 blink, 10 chase, 11 off
- freeze  in  1  hold blink and chase timers
- hex_out  out  7*NUM_DIGITS  active-low segments {g,f,e,d,c,b,a}, digit i at [7i+6:7i]
- ledr  out  NUM_LEDS  active-high LEDs
- blink_phase  out  1  1 = visible phase, 0 = hidden phase

## Operation
- Shadow registers capture on the edge where load=1. With load=0, shadows hold.
- Reset values:
  - shadow digits 0, blank_mask all 1, blink_mask 0, led_data 0, led_mode 11
  - blink counter 0, blink_phase 1, chase counter 0, chase pointer 0
  - hex_out all 1 (dark), ledr 0
- Glyphs: 0–9, A, b, C, d, E, F. 4'hF now shows F (7'b0001110). Dark = 7'h7F.
- Digit i output, in priority order:
  - blank_mask[i] → dark
  - else blink_mask[i] and blink_phase=0 → dark
  - else glyph(digit i)
- Blink timer:
  - counter runs 0..BLINK_DIV-1
  - at BLINK_DIV-1, the counter returns to 0 and blink_phase toggles
  - the timer runs in all LED modes
- LED modes:
  - direct: ledr = led_data
  - blink: ledr = led_data when blink_phase=1, else 0
  - chase: ledr is one-hot at the chase pointer. The pointer advances every CHASE_DIV cycles and wraps from NUM_LEDS-1 to 0. Loading led_mode=10 while the shadow mode ≠10 resets the pointer and chase counter to 0. Reloading 10 while already in chase does not reset them.
  - off: ledr = 0
- freeze=1: both counters, blink_phase and the chase pointer hold. load still works. Outputs still update from shadows.
- Simultaneous load and blink toggle on the same edge: both take effect. The next output reflects the new shadows with the new phase.
- resetn=0 takes priority over load and freeze, and returns everything to reset values on that edge.

## Timing
- Outputs are registered; segment decode and mode logic sit between the shadows/timers and the output registers.
- Latency from load to output is 2 edges:
  - load sampled at edge N → shadow valid after N
  - hex_out/ledr reflect it after edge N+1
- blink_phase is a direct register output. hex_out/ledr follow a toggle one edge later.
- The chase step and blink toggle follow the same one-edge output lag.
- Reset deassertion: the first possible output change occurs 2 edges after the first load.

## Structure
- Package display_pkg holds:
  - LED mode constants LED_DIRECT/LED_BLINK/LED_CHASE/LED_OFF (2-bit)
  - SEG_DARK = 7'h7F
  - glyph function seg_glyph(4-bit) → 7-bit
- Counter widths are $clog2(BLINK_DIV) and $clog2(CHASE_DIV). The chase pointer width is $clog2(NUM_LEDS), minimum 1.
- One sub-module, seg7_glyph: a purely combinational 4→7 decoder instantiated NUM_DIGITS times via generate.
- Elaboration-time checks on parameter ranges.

## Test plan
All scenarios use NUM_DIGITS=6, NUM_LEDS=10, BLINK_DIV=4, CHASE_DIV=3.
- Reset, then idle 20 cycles → hex_out all 1s, ledr 0, blink_phase toggles every 4 cycles starting from 1.
- load digit_data=24'hFEDCBA, blank_mask=0, led_mode=00, led_data=10'h2A5 at edge N → after edge N+1 HEX0=0001000 (A), HEX5=0001110 (F), ledr=2A5.
- blink_mask=6'b000001, blank_mask=6'b000010 → digit1 always 7F; digit0 alternates glyph/7F every 4 cycles in step with blink_phase (one-edge lag).
- led_mode=10 loaded from direct → ledr 001, 002, … 200, then wraps to 001, stepping every 3 cycles. Reloading 10 mid-chase causes no pointer reset.
- freeze=1 for 10 cycles mid-chase → ledr and blink_phase constant. After release, stepping resumes from the held counter values.
- load=1 and resetn=0 on the same edge → reset values win; hex_out all dark, ledr 0 after that edge.
